silife_grid_seq: RTL

- Game-of-Life cell array that sits directly downstream of the demo pattern loader.
- Accepts row writes (row_select/cells/wr_en) and generation strobes (step) from the loader, and holds the ROWS x COLS grid.
- Computes each new generation row-serially, one row per clock, to keep the area to one row of neighbour logic.
- Exposes a combinational read port for the display stage.

---
 rtl/silife_grid_seq.sv | 166 ++++++++++++++++
 1 files changed

// File: rtl/silife_grid_seq.sv
// Purpose: ROWS x COLS Game-of-Life grid (B3/S23) with row writes, row-serial generation step and combinational read port.
// Latency: step sampled at E0, rows 0..ROWS-1 rewritten at E1..E_ROWS, done pulses the cycle after E_ROWS; reads are combinational.
// Backpressure: busy high while a generation runs; wr_en/step are dropped while busy; en low freezes everything.
module silife_grid_seq #(
    parameter int ROWS  = 32,
    parameter int COLS  = 8,
    parameter int WRAP  = 1,
    parameter int GEN_W = 16,
    localparam int RW   = (ROWS > 1) ? $clog2(ROWS) : 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic [RW-1:0]    row_select,
    input  logic [COLS-1:0]  cells,
    input  logic             wr_en,
    input  logic             step,
    input  logic [RW-1:0]    rd_row,
    output logic [COLS-1:0]  rd_cells,
    output logic             busy,
    output logic             done,
    output logic [GEN_W-1:0] gen_count
);

    localparam logic WRAP_B = (WRAP != 0);

    typedef enum logic {S_IDLE, S_RUN} state_t;

    state_t            r_state;
    state_t            w_state_nxt;
    logic [COLS-1:0]   r_grid [ROWS];
    logic [COLS-1:0]   r_prev;
    logic [COLS-1:0]   r_first;
    logic [RW-1:0]     r_ptr;
    logic              r_done;
    logic [GEN_W-1:0]  r_gen_count;

    logic              w_start;
    logic              w_write;
    logic              w_adv;
    logic              w_last;
    logic [COLS-1:0]   w_cur;
    logic [COLS-1:0]   w_nxt;
    logic [COLS-1:0]   w_life;

    // Bit c of the result holds v[c-1]; column 0 sees column COLS-1 only when wrapping.
    function automatic logic [COLS-1:0] left_of(input logic [COLS-1:0] v);
        return {v[COLS-2:0], v[COLS-1] & WRAP_B};
    endfunction

    // Bit c of the result holds v[c+1]; column COLS-1 sees column 0 only when wrapping.
    function automatic logic [COLS-1:0] right_of(input logic [COLS-1:0] v);
        return {v[0] & WRAP_B, v[COLS-1:1]};
    endfunction

    assign w_last    = (r_ptr == RW'(ROWS - 1));
    assign w_cur     = r_grid[r_ptr];
    assign rd_cells  = r_grid[rd_row];
    assign busy      = (r_state == S_RUN);
    assign done      = r_done;
    assign gen_count = r_gen_count;

    // Row below the one being updated: next stored row, or the saved original row 0 at the bottom edge.
    always_comb begin
        w_nxt = '0;
        if (!w_last) begin
            w_nxt = r_grid[r_ptr + RW'(1)];
        end else if (WRAP_B) begin
            w_nxt = r_first;
        end
    end

    // One row of B3/S23 neighbour logic over prev/cur/nxt.
    always_comb begin
        logic [COLS-1:0] pl, pr, cl, cr, nl, nr;
        logic [3:0]      n;
        w_life = '0;
        n      = '0;
        pl = left_of(r_prev);  pr = right_of(r_prev);
        cl = left_of(w_cur);   cr = right_of(w_cur);
        nl = left_of(w_nxt);   nr = right_of(w_nxt);
        for (int c = 0; c < COLS; c++) begin
            n = 4'($countones({pl[c], r_prev[c], pr[c], cl[c], cr[c], nl[c], w_nxt[c], nr[c]}));
            w_life[c] = (n == 4'd3) | (w_cur[c] & (n == 4'd2));
        end
    end

    // Next-state and per-cycle strobes; a write in IDLE takes priority over a step.
    always_comb begin
        w_state_nxt = r_state;
        w_start     = 1'b0;
        w_write     = 1'b0;
        w_adv       = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (en && wr_en) begin
                    w_write = 1'b1;
                end else if (en && step) begin
                    w_start     = 1'b1;
                    w_state_nxt = S_RUN;
                end
            end
            S_RUN: begin
                if (en) begin
                    w_adv = 1'b1;
                    if (w_last) begin
                        w_state_nxt = S_IDLE;
                    end
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // State register; reset abandons any partial generation.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Row pointer plus saved context rows (row above, original row 0).
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ptr   <= '0;
            r_prev  <= '0;
            r_first <= '0;
        end else if (w_start) begin
            r_ptr   <= '0;
            r_first <= r_grid[0];
            r_prev  <= WRAP_B ? r_grid[ROWS-1] : '0;
        end else if (w_adv) begin
            r_ptr   <= w_last ? '0 : r_ptr + RW'(1);
            r_prev  <= w_cur;
        end
    end

    // Grid storage: external row writes in IDLE, in-place generation update in RUN.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int r = 0; r < ROWS; r++) begin
                r_grid[r] <= '0;
            end
        end else if (w_write) begin
            r_grid[row_select] <= cells;
        end else if (w_adv) begin
            r_grid[r_ptr] <= w_life;
        end
    end

    // Completion pulse and generation counter (wraps naturally).
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_done      <= 1'b0;
            r_gen_count <= '0;
        end else begin
            r_done <= w_adv && w_last;
            if (w_adv && w_last) begin
                r_gen_count <= r_gen_count + GEN_W'(1);
            end
        end
    end

endmodule
